// File: rtl/uart_frame_pkg.sv
// Shared frame definitions for the UART sample path and its downstream buffer.
package uart_frame_pkg;

    localparam logic [7:0]  HDR_H               = 8'hA1;
    localparam logic [7:0]  HDR_Y               = 8'hA2;
    localparam int unsigned FRAME_PAYLOAD_BYTES = 8;
    localparam int unsigned IDX_W               = $clog2(FRAME_PAYLOAD_BYTES);
    localparam int unsigned SAMPLE_W            = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] re;
        logic [SAMPLE_W-1:0] im;
    } sample_t;

endpackage

// File: rtl/frame_timeout_timer.sv
// Idle-cycle counter with clear/enable; flags the terminal count combinationally.
module frame_timeout_timer #(
    parameter int unsigned CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CNT_W-1:0] count;

    // Terminal count only matters while the frame is in progress.
    assign expire_c = enable && (count == CNT_W'(CYCLES - 1));

    // Count idle cycles; restart on any clear or after expiry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || expire_c) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_sample_assembler.sv
// Assembles checked 10-byte UART frames into H/Y complex samples.
module uart_sample_assembler
    import uart_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned ERR_W          = 8
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [31:0]      H_re_out,
    output logic [31:0]      H_im_out,
    output logic             H_value_ready,
    output logic [31:0]      Y_re_out,
    output logic [31:0]      Y_im_out,
    output logic             Y_value_ready,
    output logic             frame_err,
    output logic             timeout_err,
    output logic [ERR_W-1:0] err_count
);

    state_t           state;
    state_t           state_d;
    logic [IDX_W-1:0] idx;
    logic [7:0]       csum;
    logic             is_y;
    sample_t          asm_reg;

    logic hdr_c;
    logic shift_c;
    logic h_load_c;
    logic y_load_c;
    logic frame_err_c;
    logic timeout_c;
    logic expire_c;

    frame_timeout_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (sys_rst),
        .clear    (rx_valid || (state == IDLE)),
        .enable   (state != IDLE),
        .expire_c (expire_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and datapath strobes; a byte always beats a coincident timeout.
    always_comb begin
        state_d     = state;
        hdr_c       = 1'b0;
        shift_c     = 1'b0;
        h_load_c    = 1'b0;
        y_load_c    = 1'b0;
        frame_err_c = 1'b0;
        timeout_c   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && (rx_data == HDR_H || rx_data == HDR_Y)) begin
                    hdr_c   = 1'b1;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    shift_c = 1'b1;
                    if (idx == IDX_W'(FRAME_PAYLOAD_BYTES - 1)) begin
                        state_d = CHECK;
                    end
                end else if (expire_c) begin
                    timeout_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    state_d = IDLE;
                    if (rx_data == csum) begin
                        h_load_c = !is_y;
                        y_load_c = is_y;
                    end else begin
                        frame_err_c = 1'b1;
                    end
                end else if (expire_c) begin
                    timeout_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame assembly: type latch, byte index, shift register and running XOR.
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            is_y    <= 1'b0;
            idx     <= '0;
            csum    <= '0;
            asm_reg <= '0;
        end else if (hdr_c) begin
            is_y <= (rx_data == HDR_Y);
            idx  <= '0;
            csum <= '0;
        end else if (shift_c) begin
            asm_reg <= sample_t'({asm_reg[2*SAMPLE_W-9:0], rx_data});
            csum    <= csum ^ rx_data;
            idx     <= idx + IDX_W'(1);
        end
    end

    // Sample outputs and one-cycle event pulses.
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            H_re_out      <= '0;
            H_im_out      <= '0;
            Y_re_out      <= '0;
            Y_im_out      <= '0;
            H_value_ready <= 1'b0;
            Y_value_ready <= 1'b0;
            frame_err     <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            H_value_ready <= h_load_c;
            Y_value_ready <= y_load_c;
            frame_err     <= frame_err_c;
            timeout_err   <= timeout_c;
            if (h_load_c) begin
                H_re_out <= asm_reg.re;
                H_im_out <= asm_reg.im;
            end
            if (y_load_c) begin
                Y_re_out <= asm_reg.re;
                Y_im_out <= asm_reg.im;
            end
        end
    end

    // Saturating error counter; frame and timeout errors are mutually exclusive.
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            err_count <= '0;
        end else if ((frame_err_c || timeout_c) && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

endmodule
